// File: rtl/uart8_transmitter_if.sv
// Byte-request / serial-line bundle for uart8_transmitter.
// master = byte producer, slave = transmitter.
interface uart8_transmitter_if;
    logic       txEn;
    logic       txStart;
    logic [7:0] in;
    logic       out;
    logic       txReady;
    logic       txBusy;
    logic       txDone;

    modport master (
        output txEn, txStart, in,
        input  out, txReady, txBusy, txDone
    );

    modport slave (
        input  txEn, txStart, in,
        output out, txReady, txBusy, txDone
    );
endinterface

// File: rtl/uart8_transmitter.sv
// 8-bit UART transmitter with one-deep holding register for gap-free frames.
// Define TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart8_transmitter #(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rstN,
    uart8_transmitter_if.slave    bus
);
    localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic          stopCnt_q, stopCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          holdFull_q, holdFull_d;
    logic          done_q, done_d;
    logic          out_q, txReady_q, txBusy_q, txDone_q;
    logic          lineBit;
    logic          bitEnd;

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        bitIdx_d   = bitIdx_q;
        stopCnt_d  = 1'b0;
        shift_d    = shift_q;
        hold_d     = hold_q;
        holdFull_d = holdFull_q;
        done_d     = 1'b0;
        lineBit    = 1'b1;
        bitEnd     = (timer_q == LAST_TICK);

        // txReady_q high implies the holding register is empty
        if (bus.txEn && bus.txStart && txReady_q) begin
            hold_d     = bus.in;
            holdFull_d = 1'b1;
        end

        if (state_q != IDLE) begin
            timer_d = bitEnd ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (holdFull_q) begin
                    shift_d    = hold_q;
                    holdFull_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                lineBit = 1'b0;
                if (bitEnd) begin
                    state_d  = DATA;
                    bitIdx_d = '0;
                end
            end
            DATA: begin
                lineBit = shift_q[bitIdx_q];
                if (bitEnd) begin
                    if (bitIdx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                lineBit = (^shift_q) ^ PARITY_ODD[0];
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                lineBit   = 1'b1;
                stopCnt_d = stopCnt_q;
                if (bitEnd) begin
                    if (stopCnt_q == LAST_STOP) begin
                        done_d    = 1'b1;
                        stopCnt_d = 1'b0;
                        if (holdFull_q) begin
                            shift_d    = hold_q;
                            holdFull_d = 1'b0;
                            state_d    = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stopCnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line and status registers trail the FSM state by one cycle so every
    // output changes together at bit boundaries.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bitIdx_q   <= '0;
            stopCnt_q  <= 1'b0;
            shift_q    <= '0;
            hold_q     <= '0;
            holdFull_q <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= 1'b1;
            txReady_q  <= 1'b1;
            txBusy_q   <= 1'b0;
            txDone_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitIdx_q   <= bitIdx_d;
            stopCnt_q  <= stopCnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            holdFull_q <= holdFull_d;
            done_q     <= done_d;
            out_q      <= lineBit;
            txReady_q  <= ~(holdFull_d | holdFull_q);
            txBusy_q   <= (state_q != IDLE);
            txDone_q   <= done_q;
        end
    end

    assign bus.out     = out_q;
    assign bus.txReady = txReady_q;
    assign bus.txBusy  = txBusy_q;
    assign bus.txDone  = txDone_q;
endmodule

// File: tb/tb_uart8_transmitter.sv
// Scoreboard bench for uart8_transmitter: bytes queued on acceptance are
// compared against frames decoded from the serial line.
module tb_uart8_transmitter;
    localparam int unsigned CPB      = 1250;
    localparam int unsigned STOPS    = 1;
    localparam logic        PAR_ODD  = 1'b0;
`ifdef TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned FRAME = CPB * (10 + PAR_BITS + STOPS - 1);

    logic clk;
    logic rstN;
    uart8_transmitter_if u_if();

    uart8_transmitter #(
        .CLOCK_RATE(12000000),
        .BAUD_RATE (9600),
        .STOP_BITS (STOPS),
        .PARITY_ODD(0)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  sb[$];
    bit          mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit push);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (u_if.txReady !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME) chk("ready_timeout", 32'(n), 32'(0));
        u_if.in      = b;
        u_if.txStart = 1'b1;
        @(posedge clk);
        #1;
        u_if.txStart = 1'b0;
        if (push) sb.push_back(b);
    endtask

    // Counts negedges until txDone is seen (bounded)
    task automatic wait_done(output int unsigned k);
        k = 0;
        while (u_if.txDone !== 1'b1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Line decoder: mid-bit sampling from the falling edge of the start bit
    initial begin : monitor
        logic       prev;
        logic [7:0] d;
        logic [7:0] exp;
        logic       par;
        prev = 1'b1;
        par  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && prev == 1'b1 && u_if.out == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                chk("start_bit", 32'(u_if.out), 32'(0));
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = u_if.out;
                end
                if (PAR_BITS != 0) begin
                    repeat (CPB) @(negedge clk);
                    par = u_if.out;
                end
                for (int s = 0; s < int'(STOPS); s++) begin
                    repeat (CPB) @(negedge clk);
                    chk("stop_bit", 32'(u_if.out), 32'(1));
                end
                chk("sb_nonempty", 32'(sb.size() > 0), 32'(1));
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("rx_byte", 32'(d), 32'(exp));
                    if (PAR_BITS != 0) chk("parity_bit", 32'(par), 32'((^exp) ^ PAR_ODD));
                end
            end
            prev = u_if.out;
        end
    end

    initial begin : main
        int unsigned k;
        int unsigned cnt_a;
        int unsigned cnt_b;
        logic        prev;

        rstN         = 1'b0;
        u_if.txEn    = 1'b0;
        u_if.txStart = 1'b0;
        u_if.in      = '0;

        // Reset and long idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 32'(u_if.out), 32'(1));
        chk("rst_ready", 32'(u_if.txReady), 32'(1));
        chk("rst_busy", 32'(u_if.txBusy), 32'(0));
        chk("rst_done", 32'(u_if.txDone), 32'(0));
        rstN  = 1'b1;
        prev  = u_if.out;
        cnt_a = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (u_if.out !== prev) cnt_a++;
            prev = u_if.out;
        end
        chk("idle_edges", 32'(cnt_a), 32'(0));
        chk("idle_busy", 32'(u_if.txBusy), 32'(0));
        mon_en    = 1'b1;
        u_if.txEn = 1'b1;

        // Single byte: latency, txBusy window, txDone timing
        send(8'b00110101, 1'b1);
        @(negedge clk);
        chk("ready_low_after_accept", 32'(u_if.txReady), 32'(0));
        chk("line_high_n", 32'(u_if.out), 32'(1));
        @(negedge clk);
        chk("line_high_n1", 32'(u_if.out), 32'(1));
        chk("busy_low_n1", 32'(u_if.txBusy), 32'(0));
        @(negedge clk);
        chk("start_at_n2", 32'(u_if.out), 32'(0));
        chk("busy_at_n2", 32'(u_if.txBusy), 32'(1));
        chk("ready_at_n2", 32'(u_if.txReady), 32'(1));
        k     = 0;
        cnt_a = 0;
        while (u_if.txDone !== 1'b1 && k < 2 * FRAME) begin
            if (u_if.txBusy !== 1'b1) cnt_a++;
            @(negedge clk);
            k++;
        end
        chk("done_latency", 32'(k), 32'(FRAME));
        chk("busy_gaps", 32'(cnt_a), 32'(0));
        chk("busy_after_frame", 32'(u_if.txBusy), 32'(0));
        chk("line_after_frame", 32'(u_if.out), 32'(1));
        @(negedge clk);
        chk("done_one_cycle", 32'(u_if.txDone), 32'(0));

        // Back-to-back with an overrun attempt while the holding register is full
        send(8'h55, 1'b1);
        send(8'hA3, 1'b1);
        @(negedge clk);
        chk("ready_low_held", 32'(u_if.txReady), 32'(0));
        u_if.in      = 8'hFF;
        u_if.txStart = 1'b1;
        @(posedge clk);
        #1;
        u_if.txStart = 1'b0;
        @(negedge clk);
        wait_done(k);
        chk("b2b_first_done_seen", 32'(u_if.txDone), 32'(1));
        chk("b2b_no_gap_start", 32'(u_if.out), 32'(0));
        chk("b2b_busy_held", 32'(u_if.txBusy), 32'(1));
        @(negedge clk);
        wait_done(k);
        chk("b2b_spacing", 32'(k + 1), 32'(FRAME));
        repeat (20) @(negedge clk);
        chk("b2b_idle_after", 32'(u_if.out), 32'(1));

        // txEn low blocks requests
        u_if.txEn = 1'b0;
        @(negedge clk);
        u_if.in      = 8'h3C;
        u_if.txStart = 1'b1;
        @(posedge clk);
        #1;
        u_if.txStart = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (u_if.out !== 1'b1) cnt_a++;
            if (u_if.txBusy !== 1'b0) cnt_b++;
        end
        chk("disabled_line_low", 32'(cnt_a), 32'(0));
        chk("disabled_busy", 32'(cnt_b), 32'(0));
        chk("disabled_ready", 32'(u_if.txReady), 32'(1));
        u_if.txEn = 1'b1;

`ifdef TX_PARITY_EN
        send(8'h07, 1'b1);
        repeat (3) @(negedge clk);
        wait_done(k);
        chk("parity_done_latency", 32'(k), 32'(CPB * (11 + STOPS - 1)));
        repeat (5) @(negedge clk);
`endif

        // Reset during data bit 3 truncates the frame
        mon_en = 1'b0;
        send(8'hC3, 1'b0);
        repeat (3) @(negedge clk);
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        chk("bit3_before_reset", 32'(u_if.out), 32'(0));
        rstN = 1'b0;
        @(negedge clk);
        chk("mid_rst_out", 32'(u_if.out), 32'(1));
        chk("mid_rst_busy", 32'(u_if.txBusy), 32'(0));
        chk("mid_rst_ready", 32'(u_if.txReady), 32'(1));
        chk("mid_rst_done", 32'(u_if.txDone), 32'(0));
        rstN  = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (u_if.out !== 1'b1) cnt_a++;
            if (u_if.txBusy !== 1'b0) cnt_b++;
        end
        chk("post_rst_line", 32'(cnt_a), 32'(0));
        chk("post_rst_busy", 32'(cnt_b), 32'(0));

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
